// File: rtl/mul_pkg.sv
// Shared constants and types for the shared-multiplier arbiter.
package mul_pkg;
    localparam int SIZE   = 4;
    localparam int PROD_W = 2 * SIZE;
    localparam int LAT    = 2;
    localparam int NREQ   = 4;
    localparam int DEPTH  = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int IDW = clog2(NREQ);

    typedef struct packed {
        logic [IDW-1:0]    id;
        logic [PROD_W-1:0] product;
    } resp_entry_t;
endpackage

// File: rtl/mul_share_arb_if.sv
// Requester and response handshake bundle of the shared-multiplier arbiter.
interface mul_share_arb_if #(
    parameter int NREQ = mul_pkg::NREQ,
    parameter int SIZE = mul_pkg::SIZE,
    parameter int IDW  = mul_pkg::IDW
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*SIZE-1:0] req_a;
    logic [NREQ*SIZE-1:0] req_b;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [IDW-1:0]       resp_id;
    logic [2*SIZE-1:0]    resp_data;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data
    );
endinterface

// File: rtl/mul_resp_fifo.sv
// Result FIFO with a registered head entry that holds its value while empty.
module mul_resp_fifo
    import mul_pkg::clog2;
#(
    parameter int W     = 10,
    parameter int DEPTH = 4,
    localparam int AW   = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
    localparam int CW   = clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic [W-1:0]  head
);
    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] rd_nxt_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic [W-1:0]  head_r;
    logic [W-1:0]  head_nxt_s;

    // Next read pointer, occupancy and head value after this cycle's push/pop.
    always_comb begin
        rd_nxt_s    = pop ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
        count_nxt_s = count_r + CW'(push) - CW'(pop);
        if (count_nxt_s == '0) begin
            head_nxt_s = head_r;
        end else if (push && (rd_nxt_s == wr_ptr_r)) begin
            // The slot about to become head is being written right now.
            head_nxt_s = push_data;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s];
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            head_r   <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            rd_ptr_r <= rd_nxt_s;
            count_r  <= count_nxt_s;
            head_r   <= head_nxt_s;
        end
    end

    assign count = count_r;
    assign head  = head_r;
endmodule

// File: rtl/mul_share_arb.sv
// Round-robin sharing of one external pipelined multiplier among NREQ requesters,
// with ID tags tracked alongside the pipeline and credit-protected result buffering.
module mul_share_arb
    import mul_pkg::clog2;
#(
    parameter int SIZE  = mul_pkg::SIZE,
    parameter int NREQ  = mul_pkg::NREQ,
    parameter int LAT   = mul_pkg::LAT,
    parameter int DEPTH = mul_pkg::DEPTH,
    parameter int IDW   = mul_pkg::IDW
) (
    input  logic              clk,
    input  logic              rst,
    mul_share_arb_if.slave    bus,
    output logic [SIZE-1:0]   mul_a,
    output logic [SIZE-1:0]   mul_b,
    input  logic [2*SIZE-1:0] mul_out,
    output logic              busy
);
    localparam int CW = clog2(DEPTH) + 1;
    localparam int EW = IDW + 2 * SIZE;

    logic [IDW-1:0] ptr_r;
    logic [IDW-1:0] grant_s;
    logic           found_s;
    logic           issue_ok_s;
    logic           hs_s;
    logic [LAT-1:0] tag_vld_r;
    logic [IDW-1:0] tag_id_r [LAT];
    logic [CW-1:0]  fifo_count_s;
    logic [CW-1:0]  inflight_s;
    logic [CW:0]    credit_used_s;
    logic           pop_s;
    logic [EW-1:0]  head_s;
    int             idx_s;

    // Round-robin scan starting at ptr_r.
    always_comb begin
        found_s = 1'b0;
        grant_s = '0;
        idx_s   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s = (int'(ptr_r) + k) % NREQ;
            if (!found_s && bus.req_valid[idx_s[IDW-1:0]]) begin
                found_s = 1'b1;
                grant_s = idx_s[IDW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Number of occupied tag stages.
    always_comb begin
        inflight_s = '0;
        for (int s = 0; s < LAT; s++) begin
            inflight_s = inflight_s + CW'(tag_vld_r[s]);
        end
    end

    // Every in-flight op already owns a FIFO slot, so a push can never find it full.
    assign credit_used_s = {1'b0, fifo_count_s} + {1'b0, inflight_s};
    assign issue_ok_s    = credit_used_s < (CW + 1)'(DEPTH);
    assign hs_s          = found_s & issue_ok_s;

    // Grant strobe and operand steering toward the multiplier.
    always_comb begin
        bus.req_ready = '0;
        mul_a         = '0;
        mul_b         = '0;
        if (hs_s) begin
            bus.req_ready[grant_s] = 1'b1;
            mul_a = bus.req_a[grant_s*SIZE +: SIZE];
            mul_b = bus.req_b[grant_s*SIZE +: SIZE];
        end else begin
            bus.req_ready = '0;
        end
    end

    // Priority pointer moves past the requester just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (hs_s) begin
            ptr_r <= (int'(grant_s) == NREQ - 1) ? '0 : grant_s + IDW'(1);
        end
    end

    // Tag pipeline shadowing the multiplier latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_r <= '0;
            for (int s = 0; s < LAT; s++) begin
                tag_id_r[s] <= '0;
            end
        end else begin
            tag_vld_r[0] <= hs_s;
            tag_id_r[0]  <= grant_s;
            for (int s = 1; s < LAT; s++) begin
                tag_vld_r[s] <= tag_vld_r[s-1];
                tag_id_r[s]  <= tag_id_r[s-1];
            end
        end
    end

    mul_resp_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tag_vld_r[LAT-1]),
        .push_data ({tag_id_r[LAT-1], mul_out}),
        .pop       (pop_s),
        .count     (fifo_count_s),
        .head      (head_s)
    );

    assign bus.resp_valid = (fifo_count_s != '0);
    assign pop_s          = bus.resp_valid & bus.resp_ready;
    assign bus.resp_id    = head_s[EW-1 -: IDW];
    assign bus.resp_data  = head_s[2*SIZE-1:0];
    assign busy           = (inflight_s != '0) | (fifo_count_s != '0);
endmodule

// File: tb/tb_mul_share_arb.sv
// Randomized scoreboard bench for mul_share_arb with a behavioural arbitration/credit model.
module tb_mul_share_arb;
    import mul_pkg::*;

    localparam int NR   = 4;
    localparam int SZ   = 4;
    localparam int ID_W = 2;
    localparam int DP   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_share_arb_if #(.NREQ(NR), .SIZE(SZ), .IDW(ID_W)) bus ();

    logic [SZ-1:0]   mul_a;
    logic [SZ-1:0]   mul_b;
    logic [2*SZ-1:0] mul_out;
    logic [2*SZ-1:0] mul_p1;
    logic            busy;

    mul_share_arb #(
        .SIZE(SZ), .NREQ(NR), .LAT(2), .DEPTH(DP), .IDW(ID_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .mul_a   (mul_a),
        .mul_b   (mul_b),
        .mul_out (mul_out),
        .busy    (busy)
    );

    // External two-stage multiplier; it keeps running through reset.
    always @(posedge clk) begin
        mul_p1  <= mul_a * mul_b;
        mul_out <= mul_p1;
    end

    typedef struct {
        resp_entry_t e;
        int          avail;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          outstanding = 0;
    int          mptr = 0;
    bit          popped = 1'b0;
    resp_entry_t last;
    bit          exp_v;
    bit          found;
    bit          hs;
    int          g;
    int          idx;
    logic [NR-1:0] exp_rdy;
    logic [SZ-1:0] ea;
    logic [SZ-1:0] eb;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", name, got, exp, cyc);
        end
    endtask

    // Monitor: compares presented responses against the scoreboard head.
    always @(negedge clk) begin
        popped = 1'b0;
        if (rst) begin
            last = '0;
        end else begin
            exp_v = (q.size() != 0) && (q[0].avail <= cyc);
            check("resp_valid", 32'(bus.resp_valid), 32'(exp_v));
            check("busy", 32'(busy), 32'(outstanding != 0));
            if (exp_v) begin
                check("resp_id", 32'(bus.resp_id), 32'(q[0].e.id));
                check("resp_data", 32'(bus.resp_data), 32'(q[0].e.product));
                if (bus.resp_ready) begin
                    last = q[0].e;
                    void'(q.pop_front());
                    popped = 1'b1;
                end
            end else begin
                check("hold_id", 32'(bus.resp_id), 32'(last.id));
                check("hold_data", 32'(bus.resp_data), 32'(last.product));
            end
        end
    end

    // Reference model: round-robin grant, credit limit, scoreboard push.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            q.delete();
            outstanding = 0;
            mptr = 0;
        end else begin
            found = 1'b0;
            g = 0;
            for (int k = 0; k < NR; k++) begin
                idx = (mptr + k) % NR;
                if (!found && bus.req_valid[idx]) begin
                    found = 1'b1;
                    g = idx;
                end
            end
            hs = found && (outstanding < DP);
            exp_rdy = '0;
            ea = '0;
            eb = '0;
            if (hs) begin
                exp_rdy[g] = 1'b1;
                ea = bus.req_a[g*SZ +: SZ];
                eb = bus.req_b[g*SZ +: SZ];
            end
            check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
            check("mul_a", 32'(mul_a), 32'(ea));
            check("mul_b", 32'(mul_b), 32'(eb));
            if (hs) begin
                exp_t x;
                x.e.id      = ID_W'(g);
                x.e.product = (2*SZ)'(int'(ea) * int'(eb));
                x.avail     = cyc + 3;
                q.push_back(x);
                outstanding++;
                mptr = (g + 1) % NR;
            end
            if (popped) begin
                outstanding--;
            end
        end
        cyc++;
    end

    task automatic drive(input logic [NR-1:0] v, input logic [NR*SZ-1:0] a,
                         input logic [NR*SZ-1:0] b, input logic rr);
        bus.req_valid  = v;
        bus.req_a      = a;
        bus.req_b      = b;
        bus.resp_ready = rr;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [NR*SZ-1:0] va;
    logic [NR*SZ-1:0] vb;

    initial begin
        rst = 1'b1;
        drive('0, '0, '0, 1'b1);
        step(2);
        rst = 1'b0;
        step(2);

        // Single op from requester 2: 7 * 9.
        va = '0; vb = '0;
        va[2*SZ +: SZ] = 4'd7;
        vb[2*SZ +: SZ] = 4'd9;
        drive(4'b0100, va, vb, 1'b1);
        step(1);
        drive('0, '0, '0, 1'b1);
        step(6);

        // Contention: everybody valid, a=i+1, b=15.
        for (int i = 0; i < NR; i++) begin
            va[i*SZ +: SZ] = SZ'(i + 1);
            vb[i*SZ +: SZ] = 4'd15;
        end
        drive(4'b1111, va, vb, 1'b1);
        step(9);
        drive('0, '0, '0, 1'b1);
        step(6);

        // Backpressure: requester 0 streams 15*15 while the consumer stalls.
        va = '0; vb = '0;
        va[0 +: SZ] = 4'd15;
        vb[0 +: SZ] = 4'd15;
        drive(4'b0001, va, vb, 1'b0);
        step(8);
        drive(4'b0001, va, vb, 1'b1);
        step(10);
        drive('0, '0, '0, 1'b1);
        step(6);

        // Boundary operands on requester 1.
        va = '0; vb = '0;
        va[SZ +: SZ] = 4'd0;  vb[SZ +: SZ] = 4'd15;
        drive(4'b0010, va, vb, 1'b1);
        step(1);
        va[SZ +: SZ] = 4'd15; vb[SZ +: SZ] = 4'd0;
        drive(4'b0010, va, vb, 1'b1);
        step(1);
        va[SZ +: SZ] = 4'd15; vb[SZ +: SZ] = 4'd15;
        drive(4'b0010, va, vb, 1'b1);
        step(1);
        drive('0, '0, '0, 1'b1);
        step(6);

        // Reset with two ops buffered and two in flight.
        va = '0; vb = '0;
        va[3*SZ +: SZ] = 4'd5;
        vb[3*SZ +: SZ] = 4'd3;
        drive(4'b1000, va, vb, 1'b0);
        step(4);
        drive('0, '0, '0, 1'b0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        drive(4'b1111, 16'h1234, 16'h5678, 1'b1);
        step(3);
        drive('0, '0, '0, 1'b1);
        step(8);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            drive(NR'($urandom), (NR*SZ)'($urandom), (NR*SZ)'($urandom),
                  $urandom_range(0, 3) != 0);
            step(1);
        end
        drive('0, '0, '0, 1'b1);
        step(12);
        check("drain_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
- Shares one pipelined SIZE x SIZE unsigned multiplier (2-cycle latency, no stall input) among NREQ requesters.
- Arbitration is round-robin with valid/ready handshakes on each requester port.
- Each operation is tagged with its requester ID, the tag is tracked alongside the multiplier pipeline, and every product is returned through a credit-protected result FIFO.
- Sits between requester blocks and the multiplier instance. The multiplier itself stays outside this block.

Parameters:
- SIZE, 4, operand width; product width is 2*SIZE.
- NREQ, 4, number of requesters (>=2).
- LAT, 2, multiplier latency in clock edges from operand presentation to valid mul_out.
- DEPTH, 4, result FIFO entries (power of 2, >= LAT).
- IDW, 2, requester ID width, equal to clog2(NREQ).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  NREQ  per-requester operation valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_a  input  NREQ*SIZE  packed operand A; requester i occupies bits [i*SIZE +: SIZE].
- req_b  input  NREQ*SIZE  packed operand B, same packing.
- mul_a  output  SIZE  operand A to multiplier.
- mul_b  output  SIZE  operand B to multiplier.
- mul_out  input  2*SIZE  product from multiplier.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_id  output  IDW  requester ID of the result.
- resp_data  output  2*SIZE  product.
- busy  output  1  any operation in flight or any FIFO entry occupied.

Behaviour:
- Reset, synchronous on rst=1 at a clock edge:
  - Round-robin pointer cleared, so requester 0 has highest priority.
  - Tag pipeline valids cleared; FIFO empty.
  - Outputs after reset: req_ready=0 until the first evaluation, resp_valid=0, resp_id=0, resp_data=0, busy=0.
- Reset mid-operation: in-flight and buffered results are discarded. Any products the multiplier later emits are ignored, because their pipeline valids are already cleared.
- Credit:
  - inflight = count of valid pipeline stages.
  - issue_ok = (fifo_count + inflight) < DEPTH.
  - Backpressure on resp_ready therefore can never cause a product to be lost.
- Arbitration (combinational):
  - Scan req_valid starting at ptr, wrapping modulo NREQ; the first asserted requester is the grant g.
  - req_ready[g] = issue_ok. All other req_ready bits are 0.
  - req_ready does not depend on resp_ready in the same cycle.
- Issue: a handshake is req_valid[g] & req_ready[g].
  - mul_a/mul_b = req_a/req_b slice of g when a handshake occurs, otherwise 0.
  - The handshake pushes {1, g} into stage 0 of the tag pipeline; with no handshake, stage 0 gets valid=0.
  - ptr <= (g+1) mod NREQ on handshake only; otherwise unchanged.
- Tag pipeline:
  - LAT registered stages that shift every cycle with no stall.
  - When the last stage is valid, mul_out is the product for that tag. {tag, mul_out} is written to the FIFO in that cycle.
  - Throughput is one issue per cycle when credit allows.
  - Minimum issue-to-resp_valid latency is LAT+1 cycles: LAT stages plus the FIFO write.
- FIFO:
  - resp_valid = not empty; resp_id/resp_data = head entry.
  - Pop on resp_valid & resp_ready.
  - Push and pop in the same cycle are both honoured, and fifo_count is unchanged.
  - Push while full cannot occur; the credit rule guarantees it. Verification asserts this.
  - Pointers wrap modulo DEPTH.
  - resp_data/resp_id hold their last value while the FIFO is empty.
- Arithmetic: the controller does no arithmetic on data. Products are stored unmodified at 2*SIZE bits.
- busy = (inflight != 0) | (fifo_count != 0).

Decomposition:
- Shared package mul_pkg holds:
  - SIZE, PROD_W = 2*SIZE, LAT, and a clog2 function;
  - typedef resp_entry_t = {id, product}.
- One sub-module, mul_resp_fifo: synchronous FIFO of DEPTH entries with count output, push/pop, and synchronous active-high reset.
- Arbiter and tag pipeline stay in the top module.

Test Plan:
- Single op: requester 2 issues a=7, b=9 with resp_ready=1 → req_ready[2]=1 in the same cycle; resp_valid rises 3 cycles later with resp_id=2, resp_data=63.
- Contention: all four requesters valid every cycle, a=i+1, b=15, resp_ready=1 → grants in order 0,1,2,3,0 on consecutive cycles. Responses follow in grant order with data 15, 30, 45, 60, 15.
- Backpressure: hold resp_ready=0 while requester 0 streams a=15, b=15 → exactly 4 handshakes, then req_ready=0. The FIFO holds 4×225 with no overflow. Raising resp_ready drains one entry per cycle, and issue resumes the cycle after the first pop frees credit.
- Simultaneous push and pop: steady stream with resp_ready=1 → fifo_count stays constant and there is one response per cycle.
- Reset mid-operation: assert rst for 1 cycle with 2 ops in flight and 2 buffered → resp_valid=0 and busy=0 the next cycle, no stale response ever appears, and the next grant goes to requester 0.
- Boundary operands: a=0, b=15 and a=15, b=0 → resp_data=0. Then a=15, b=15 → resp_data=225 (8'hE1).
